// File: rtl/riscv_pkg.sv
// riscv_pkg: shared front-end constants and the fetch buffer entry type
package riscv_pkg;
   localparam int xlen = 32;
   localparam logic [31:0] nop_instr = 32'h0000_0013;
   localparam logic [31:0] instr_step = 32'd4;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous circular buffer of fetched {pc, instr} entries with flush
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int depth = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  fetch_entry_t            din,
   output fetch_entry_t            head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(depth):0]  count
);
   localparam int aw = $clog2(depth);
   localparam logic [aw:0] full_cnt = (aw + 1)'(depth);
   fetch_entry_t mem [depth];
   logic [aw-1:0] wr_ptr, rd_ptr;
   assign head  = mem[rd_ptr];
   assign full  = count == full_cnt;
   assign empty = count == '0;
   // Pointers wrap naturally since depth is a power of two; a full push with a pop reuses the head slot.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from instruction memory into a decoupling buffer, presents entries to decode
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] reset_pc  = 32'h0000_0000,
   parameter int          buf_depth = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        halt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [31:0] fetch_count
);
   localparam int cw = $clog2(buf_depth) + 1;
   localparam logic [cw-1:0] fill_max = cw'(buf_depth);
   logic [31:0]   pc;
   logic          push, pop, full, empty;
   logic [cw-1:0] fill;
   fetch_entry_t  head;
   assign imem_addr = pc;
   fetch_fifo #(.depth(buf_depth)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ('{pc: pc, instr: imem_instr}),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (fill)
   );
   // A redirect hides the stale head so nothing is consumed while the buffer is flushed.
   always_comb begin
      out_valid = !empty && !redirect_valid;
      pop       = out_valid && out_ready;
      push      = !rst && !redirect_valid && !halt && (fill < fill_max || pop);
      out_pc    = empty ? '0 : head.pc;
      out_instr = empty ? nop_instr : head.instr;
   end
   // PC and fetch counter advance only on an accepted push; redirects reload the word-aligned target.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= reset_pc;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         pc <= {redirect_target[31:2], 2'b00};
      end else if (push) begin
         pc          <= pc + instr_step;
         fetch_count <= fetch_count + 32'd1;
      end
   end
   // The full flag and the fill count must always agree.
   always @(posedge clk) begin
      if (!rst) assert (full == (fill == fill_max));
   end
endmodule
